// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_pkg
// Brief    : Shared access-size encodings, responder FSM states and helpers
//            for the MEM-stage data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

  // Access size encodings as carried on req_size
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Number of bytes touched by an access of the given size (1, 2, 4 or 8)
  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : MEM-stage load/store request channel (valid/ready) plus the
//            one-cycle response pulse.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  // Pipeline side: issues requests, consumes responses
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  // Memory side: accepts requests, produces responses
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dmem_lane_align
// Brief    : Combinational byte-lane steering for a 64-bit little-endian
//            word: store byte enables and data shift, load shift/extend.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import rv_mem_pkg::*;
(
  input  wire  logic [2:0]  offset,
  input  wire  logic [1:0]  size,
  input  wire  logic        is_unsigned,
  input  wire  logic [63:0] wdata,
  input  wire  logic [63:0] rword,
  output logic [7:0]        byte_en,
  output logic [63:0]       wdata_sh,
  output logic [63:0]       rdata_ext
);

  logic [7:0]  base_mask;
  logic [63:0] rword_sh;

  // Steer store lanes and extract/extend the addressed load bytes
  always_comb begin
    // 8'hFF >> (8 - nbytes) gives nbytes low ones without a 9th bit
    base_mask = 8'hFF >> (4'd8 - size_bytes(size));
    byte_en   = base_mask << offset;
    wdata_sh  = wdata << {offset, 3'b000};
    rword_sh  = rword >> {offset, 3'b000};
    rdata_ext = rword_sh;
    case (size)
      SZ_B: rdata_ext = is_unsigned ? {56'd0, rword_sh[7:0]}
                                    : {{56{rword_sh[7]}}, rword_sh[7:0]};
      SZ_H: rdata_ext = is_unsigned ? {48'd0, rword_sh[15:0]}
                                    : {{48{rword_sh[15]}}, rword_sh[15:0]};
      SZ_W: rdata_ext = is_unsigned ? {32'd0, rword_sh[31:0]}
                                    : {{32{rword_sh[31]}}, rword_sh[31:0]};
      SZ_D: rdata_ext = rword_sh;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory target for the MEM stage. One request at a time,
//            programmable access latency, little-endian B/H/W/D access with
//            sign/zero extension and misalign/range error reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import rv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  wire logic        clk,
  input  wire logic        reset,   // asynchronous, active low
  dmem_responder_if.slave  bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [60:0] DEPTH_W61 = 61'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  // Storage is deliberately not reset; contents survive a pipeline reset
  logic [63:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] word_idx;
  logic             misaligned;
  logic             out_of_range;
  logic             acc_err;
  logic             commit;
  logic [7:0]       byte_en;
  logic [63:0]      wdata_sh;
  logic [63:0]      rdata_ext;
  logic [63:0]      rword;

  assign word_idx     = addr_q[3 +: IDX_W];
  assign misaligned   = (addr_q[2:0] & 3'(size_bytes(size_q) - 4'd1)) != 3'd0;
  assign out_of_range = addr_q[63:3] >= DEPTH_W61;
  assign acc_err      = misaligned | out_of_range;
  assign rword        = mem[word_idx];
  // Last WAIT cycle: the edge ending it both reads and writes the array
  assign commit       = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  dmem_lane_align u_lane_align (
    .offset      (addr_q[2:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_sh    (wdata_sh),
    .rdata_ext   (rdata_ext)
  );

  // Next-state logic: capture in IDLE, count down in WAIT, pulse in RESP
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          write_d     = bus.req_write;
          size_d      = bus.req_size;
          uns_d       = bus.req_unsigned;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          cnt_d       = CNT_LOAD;
          state_d     = ST_WAIT;
          req_ready_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = acc_err;
          rsp_rdata_d = (acc_err || write_q) ? 64'd0 : rdata_ext;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State, capture and registered response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      size_q      <= SZ_B;
      uns_q       <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-masked store commit; reset forces IDLE so a pending store is lost
  always_ff @(posedge clk) begin
    if (commit && write_q && !acc_err) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Self-checking bench for dmem_responder: directed scenarios plus
//            randomized traffic against a byte-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
  import rv_mem_pkg::*;

  localparam int DEPTH = 512;
  localparam int LAT   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  // Reference memory, one entry per byte address
  logic [7:0] mem_b [DEPTH*8];

  dmem_responder_if bus();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: byte-at-a-time little-endian access with extension
  function automatic void model(input bit wr, input logic [1:0] sz, input bit uns,
                                input logic [63:0] addr, input logic [63:0] wd,
                                output logic [63:0] rd, output bit err);
    int n;
    n   = 1 << sz;
    rd  = '0;
    err = ((addr % 64'(n)) != 64'd0) || (addr >= 64'(DEPTH*8));
    if (err) return;
    for (int i = 0; i < n; i++) begin
      if (wr) mem_b[int'(addr[15:0]) + i] = wd[8*i +: 8];
      else    rd[8*i +: 8] = mem_b[int'(addr[15:0]) + i];
    end
    if (!wr && !uns && n < 8 && rd[8*n-1])
      for (int i = n; i < 8; i++) rd[8*i +: 8] = 8'hFF;
  endfunction

  // One complete request/response with protocol and data checks
  task automatic xact(input string tag, input bit wr, input logic [1:0] sz, input bit uns,
                      input logic [63:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd, output bit er);
    logic [63:0] exp_rd;
    bit          exp_err;
    int          n;
    model(wr, sz, uns, addr, wd, exp_rd, exp_err);
    @(negedge clk);
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    // Drop valid and scramble fields: the captured request must be used
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = {$urandom, $urandom};
    bus.req_wdata    = {$urandom, $urandom};
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < LAT + 8);
    chk({tag, ".latency"}, 64'(n), 64'(LAT + 1));
    chk({tag, ".ready_in_resp"}, 64'(bus.req_ready), 64'd0);
    chk({tag, ".rdata"}, bus.rsp_rdata, exp_rd);
    chk({tag, ".err"}, 64'(bus.rsp_err), 64'(exp_err));
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(negedge clk);
    chk({tag, ".valid_pulse"}, 64'(bus.rsp_valid), 64'd0);
    chk({tag, ".ready_back"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ".rdata_hold"}, bus.rsp_rdata, exp_rd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] r, r0, w10, addr, wd;
    bit          e, seen;
    logic [1:0]  sz;
    int          sel;

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'd0;
    bus.req_wdata    = 64'd0;

    // Reset low for three cycles, then idle outputs
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset.ready", 64'(bus.req_ready), 64'd1);
    chk("reset.valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset.rdata", bus.rsp_rdata, 64'd0);
    chk("reset.err",   64'(bus.rsp_err), 64'd0);

    // Known contents for words 0..31
    for (int i = 0; i < 32; i++)
      xact("init", 1'b1, SZ_D, 1'b0, 64'(i * 8), {$urandom, $urandom}, r, e);

    // Double store then load
    xact("st40", 1'b1, SZ_D, 1'b0, 64'h40, 64'h1122334455667788, r, e);
    chk("st40.rd0", r, 64'd0);
    xact("ld40", 1'b0, SZ_D, 1'b0, 64'h40, 64'd0, r, e);
    chk("ld40.val", r, 64'h1122334455667788);
    chk("ld40.err", 64'(e), 64'd0);

    // Byte/half loads with extension
    xact("st80", 1'b1, SZ_D, 1'b0, 64'h80, 64'h00000000000080FF, r, e);
    xact("lb80", 1'b0, SZ_B, 1'b0, 64'h80, 64'd0, r, e);
    chk("lb80.val", r, 64'hFFFFFFFFFFFFFFFF);
    xact("lhu80", 1'b0, SZ_H, 1'b1, 64'h80, 64'd0, r, e);
    chk("lhu80.val", r, 64'h00000000000080FF);
    xact("lb81", 1'b0, SZ_B, 1'b0, 64'h81, 64'd0, r, e);
    chk("lb81.val", r, 64'hFFFFFFFFFFFFFF80);

    // Partial word store into upper half
    xact("st80b", 1'b1, SZ_D, 1'b0, 64'h80, 64'h0123456789ABCDEF, r, e);
    xact("sw84", 1'b1, SZ_W, 1'b0, 64'h84, 64'h00000000DEADBEEF, r, e);
    xact("ld80", 1'b0, SZ_D, 1'b0, 64'h80, 64'd0, r, e);
    chk("ld80.val", r, 64'hDEADBEEF89ABCDEF);

    // Errors: misaligned store leaves memory alone; out-of-range load
    xact("ld0a", 1'b0, SZ_D, 1'b0, 64'h0, 64'd0, r0, e);
    xact("sh03", 1'b1, SZ_H, 1'b0, 64'h3, 64'h000000000000BEEF, r, e);
    chk("sh03.err", 64'(e), 64'd1);
    chk("sh03.rd0", r, 64'd0);
    xact("ld0b", 1'b0, SZ_D, 1'b0, 64'h0, 64'd0, r, e);
    chk("sh03.mem", r, r0);
    xact("ldoor", 1'b0, SZ_D, 1'b0, 64'(DEPTH * 8), 64'd0, r, e);
    chk("ldoor.err", 64'(e), 64'd1);

    // Reset in cycle 1 of a store: no response, no memory change
    xact("ld10a", 1'b0, SZ_D, 1'b0, 64'h10, 64'd0, w10, e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_size  = SZ_B;
    bus.req_addr  = 64'h10;
    bus.req_wdata = 64'hAA;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.ready", 64'(bus.req_ready), 64'd1);
    seen = bus.rsp_valid;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst.rdata", bus.rsp_rdata, 64'd0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rst.no_resp", 64'(seen), 64'd0);
    xact("ld10b", 1'b0, SZ_D, 1'b0, 64'h10, 64'd0, r, e);
    chk("rst.mem", r, w10);

    // Randomized traffic within the initialized region plus error cases
    for (int t = 0; t < 200; t++) begin
      sz  = 2'($urandom);
      sel = $urandom_range(0, 19);
      if (sel == 0)      addr = 64'(DEPTH * 8) + 64'($urandom_range(0, 4095));
      else if (sel == 1) addr = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      else if (sel < 5)  addr = 64'($urandom_range(0, 255));
      else               addr = 64'($urandom_range(0, 255)) & ~(64'(1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      xact("rand", ($urandom_range(0, 2) == 0), sz, 1'($urandom), addr, wd, r, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the 5-stage RV64 pipeline. It is the target side of the MEM-stage load/store interface and serves one request at a time over a valid/ready request channel and a one-cycle response pulse. It performs little-endian byte/half/word/double access with sign or zero extension, and adds a configurable access latency so the pipeline's stall path can be exercised. It replaces the zero-latency data memory inside the MEM stage.

## Interface
Parameters:
- DEPTH_WORDS, 512: number of 64-bit words; valid byte addresses are 0 .. 8*DEPTH_WORDS-1.
- LATENCY, 2: wait cycles between accept and response; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
- req_unsigned  input  1  load zero-extends when 1; ignored for double and for stores.
- req_addr  input  64  byte address.
- req_wdata  input  64  store data, LSB-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  64  load result; 0 for stores and errors.
- rsp_err  output  1  misaligned or out-of-range access; qualified by rsp_valid.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. If req_valid is sampled high, capture write/size/unsigned/addr/wdata, load the counter with LATENCY-1, go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle. At 0, go to RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then unconditionally IDLE. Inputs are ignored during RESP.
- Error check, on captured fields:
  - misaligned when addr[2:0] is not a multiple of (1<<size);
  - out of range when addr[63:3] >= DEPTH_WORDS.
  - On error: rsp_err=1, rsp_rdata=0, no memory change.
- Store: byte-enable mask = ((1<<(1<<size))-1) << addr[2:0]. Write data is req_wdata shifted left by 8*addr[2:0]. Only enabled bytes of mem[addr[63:3]] change. The write commits on the edge entering RESP.
- Load: word = mem[addr[63:3]] read on the edge entering RESP. Shift right by 8*addr[2:0], truncate to the size, then sign- or zero-extend to 64.
- Memory contents are not cleared by reset. Initial contents come from simulation preload only.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- rsp_rdata and rsp_err are registered and hold their last value outside RESP.
- Latency and throughput:
  - Accept edge at the end of cycle 0. WAIT occupies cycles 1..LATENCY. rsp_valid is high in cycle LATENCY+1. req_ready returns high in cycle LATENCY+2.
  - Throughput is one request per LATENCY+2 cycles.
- req_valid may drop while in WAIT without effect: the captured request completes.
- Reset asserted mid-operation returns to IDLE immediately. A store not yet committed (reset before the RESP edge) is discarded. No response is produced.
- rsp_valid and req_ready are never high in the same cycle.

## Structure
- Package rv_mem_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - the FSM state enum;
  - the function size_bytes(size).
- Sub-module dmem_lane_align (combinational) holds:
  - inputs: addr[2:0], size, unsigned, wdata, rword;
  - outputs: byte mask, shifted wdata, extended load data.
- The top keeps the FSM, counter, capture registers and memory array.

## Test plan
- Reset then idle: reset low for 3 cycles, then high → req_ready=1, rsp_valid=0, rsp_rdata=0.
- Double store then load: store 0x1122334455667788 at 0x40, then load double at 0x40 with LATENCY=2.
  - rsp_valid in cycle 3 after each accept; load rdata=0x1122334455667788; err=0.
- Byte load and extension: preload 0x00000000000080FF at 0x80. Load byte signed at 0x80 → 0xFFFFFFFFFFFFFFFF. Load half unsigned at 0x80 → 0x80FF. Load byte signed at 0x81 → 0xFFFFFFFFFFFFFF80.
- Partial store: store word 0xDEADBEEF at 0x84 over 0x0123456789ABCDEF → load double at 0x80 returns 0xDEADBEEF89ABCDEF.
- Errors:
  - half store at 0x03 → rsp_err=1, rdata=0, memory unchanged;
  - load at 8*DEPTH_WORDS → rsp_err=1.
- Reset mid-store: accept store 0xAA at 0x10, assert reset in cycle 1 → no rsp_valid; a subsequent load of 0x10 returns its original value.
